// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported MEM-stage data memory between the CPU
// load/store path and a DMA/loader port. The CPU has fixed priority, except when
// the DMA has waited MAX_WAIT cycles. The winning access is registered onto the
// memory bus, and read data is returned to its owner two cycles after grant.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  // Data memory
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0]        r_wait_cnt;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_iss_owner;  // 1 = DMA owns the issued access
  logic              r_ret_valid;
  logic              r_ret_owner;

  logic              w_dma_gnt;
  logic              w_cpu_gnt;
  logic              w_any_gnt;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Arbitration and winner mux: DMA wins when CPU is idle or DMA has waited long enough.
  always_comb begin
    w_dma_gnt   = dma_req & (~cpu_req | (r_wait_cnt == MaxWait));
    w_cpu_gnt   = cpu_req & ~w_dma_gnt;
    w_any_gnt   = w_dma_gnt | w_cpu_gnt;
    w_sel_we    = w_dma_gnt ? dma_we    : cpu_we;
    w_sel_addr  = w_dma_gnt ? dma_addr  : cpu_addr;
    w_sel_wdata = w_dma_gnt ? dma_wdata : cpu_wdata;
  end

  // Anti-starvation counter: counts DMA wait cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_dma_gnt || !dma_req) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt < MaxWait) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Issue register: strobes pulse for one cycle per grant; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_iss_owner <= 1'b0;
    end else if (w_any_gnt) begin
      r_mem_read  <= ~w_sel_we;
      r_mem_write <= w_sel_we;
      r_mem_addr  <= w_sel_addr;
      r_mem_wdata <= w_sel_wdata;
      r_iss_owner <= w_dma_gnt;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  end

  // Return register: tracks which port the read data arriving next cycle belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_valid <= 1'b0;
      r_ret_owner <= 1'b0;
    end else begin
      r_ret_valid <= r_mem_read;
      r_ret_owner <= r_iss_owner;
    end
  end

  // Output drive: rdata is a pass-through, rvalid is steered to the owner only.
  always_comb begin
    cpu_gnt    = w_cpu_gnt;
    dma_gnt    = w_dma_gnt;
    stall      = cpu_req & ~w_cpu_gnt;
    mem_read   = r_mem_read;
    mem_write  = r_mem_write;
    mem_addr   = r_mem_addr;
    mem_wdata  = r_mem_wdata;
    cpu_rvalid = r_ret_valid & ~r_ret_owner;
    dma_rvalid = r_ret_valid & r_ret_owner;
    cpu_rdata  = mem_rdata;
    dma_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (ADDR_W=DATA_W=64, MAX_WAIT=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units after.
module tb_dmem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk;
  logic          rst_n;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_rvalid, stall, dma_gnt, dma_rvalid;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_vec;
  int n_err;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_rdata = '0;
    rst_n = 0;
    cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      n_vec++;
      if ({mem_read, mem_write, cpu_rvalid, dma_rvalid} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_strobes: got %b want 0000",
                 {mem_read, mem_write, cpu_rvalid, dma_rvalid});
      end
      n_vec++;
      if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
        n_err++;
        $display("FAIL reset_bus: addr %h wdata %h want 0", mem_addr, mem_wdata);
      end
      n_vec++;
      if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL reset_gnt: cpu_gnt %b dma_gnt %b want 1 0", cpu_gnt, dma_gnt);
      end
    end
    next_cycle();
    rst_n = 1;
    #1;
    n_vec++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL first_gnt: cpu_gnt %b dma_gnt %b stall %b want 1 0 0",
               cpu_gnt, dma_gnt, stall);
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h40;
    #1;
    n_vec++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_rd_gnt: cpu_gnt %b dma_gnt %b want 1 0", cpu_gnt, dma_gnt);
    end
    next_cycle();
    cpu_req = 0;
    #1;
    n_vec++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 64'h40) begin
      n_err++;
      $display("FAIL cpu_rd_issue: rd %b wr %b addr %h want 1 0 40",
               mem_read, mem_write, mem_addr);
    end
    next_cycle();
    mem_rdata = 64'hDEAD_BEEF;
    #1;
    n_vec++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 64'hDEAD_BEEF || dma_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_rd_data: rvalid %b rdata %h dma_rvalid %b want 1 deadbeef 0",
               cpu_rvalid, cpu_rdata, dma_rvalid);
    end
    next_cycle();
    #1;
    n_vec++;
    if (cpu_rvalid !== 1'b0 || mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_rd_done: rvalid %b mem_read %b want 0 0", cpu_rvalid, mem_read);
    end
  endtask

  task automatic test_dma_write();
    next_cycle();
    dma_req = 1; dma_we = 1; dma_addr = 64'h80; dma_wdata = 64'h1234;
    #1;
    n_vec++;
    if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL dma_wr_gnt: dma_gnt %b cpu_gnt %b want 1 0", dma_gnt, cpu_gnt);
    end
    next_cycle();
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    #1;
    n_vec++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 64'h1234 ||
        mem_addr !== 64'h80) begin
      n_err++;
      $display("FAIL dma_wr_issue: wr %b rd %b wdata %h addr %h want 1 0 1234 80",
               mem_write, mem_read, mem_wdata, mem_addr);
    end
    next_cycle();
    #1;
    n_vec++;
    if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || mem_write !== 1'b0 ||
        mem_addr !== 64'h80) begin
      n_err++;
      $display("FAIL dma_wr_after: rvalid %b/%b wr %b addr %h want 0/0 0 80",
               cpu_rvalid, dma_rvalid, mem_write, mem_addr);
    end
  endtask

  task automatic test_contention();
    logic exp_dma;
    next_cycle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 64'h10; cpu_wdata = 64'h1;
    dma_req = 1; dma_we = 1; dma_addr = 64'h20; dma_wdata = 64'h2;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_dma = ((i % 5) == 4);
      n_vec++;
      if (dma_gnt !== exp_dma || cpu_gnt !== !exp_dma || stall !== exp_dma) begin
        n_err++;
        $display("FAIL contend[%0d]: dma_gnt %b cpu_gnt %b stall %b want %b %b %b",
                 i, dma_gnt, cpu_gnt, stall, exp_dma, !exp_dma, exp_dma);
      end
      n_vec++;
      if (dut.r_wait_cnt !== 4'(i % 5)) begin
        n_err++;
        $display("FAIL contend_wait[%0d]: wait_cnt %0d want %0d", i, dut.r_wait_cnt, i % 5);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h100;
    #1;
    n_vec++;
    if (cpu_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_cpu_gnt: got %b want 1", cpu_gnt);
    end
    next_cycle();
    cpu_req = 0;
    dma_req = 1; dma_we = 0; dma_addr = 64'h200;
    #1;
    n_vec++;
    if (dma_gnt !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 64'h100) begin
      n_err++;
      $display("FAIL b2b_n1: dma_gnt %b rd %b addr %h want 1 1 100",
               dma_gnt, mem_read, mem_addr);
    end
    next_cycle();
    dma_req = 0;
    mem_rdata = 64'hAAAA_0001;
    #1;
    n_vec++;
    if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || cpu_rdata !== 64'hAAAA_0001 ||
        mem_read !== 1'b1 || mem_addr !== 64'h200) begin
      n_err++;
      $display("FAIL b2b_n2: cpu_rv %b dma_rv %b rdata %h rd %b addr %h want 1 0 aaaa0001 1 200",
               cpu_rvalid, dma_rvalid, cpu_rdata, mem_read, mem_addr);
    end
    next_cycle();
    mem_rdata = 64'hBBBB_0002;
    #1;
    n_vec++;
    if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dma_rdata !== 64'hBBBB_0002) begin
      n_err++;
      $display("FAIL b2b_n3: dma_rv %b cpu_rv %b rdata %h want 1 0 bbbb0002",
               dma_rvalid, cpu_rvalid, dma_rdata);
    end
    next_cycle();
    #1;
    n_vec++;
    if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_n4: dma_rv %b cpu_rv %b want 0 0", dma_rvalid, cpu_rvalid);
    end
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h300;
    #1;
    n_vec++;
    if (cpu_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rst_fl_gnt: got %b want 1", cpu_gnt);
    end
    next_cycle();
    cpu_req = 0;
    rst_n = 0;
    #1;
    n_vec++;
    if (mem_read !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_fl_clear: rd %b rvalid %b want 0 0", mem_read, cpu_rvalid);
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i == 1) rst_n = 1;
      #1;
      n_vec++;
      if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_fl_rv[%0d]: cpu %b dma %b want 0 0", i, cpu_rvalid, dma_rvalid);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_contention();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory of the MEM stage between the CPU load/store path and a DMA/loader port. Each cycle it grants at most one requester, registers the winning access onto the memory interface, and routes the read data back to its owner two cycles after grant. The CPU has fixed priority, bounded by an anti-starvation counter for the DMA port. It generates the pipeline stall for the MEM stage.

## Interface

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MAX_WAIT, 4, DMA wait cycles before it overrides CPU priority; legal range 1..15

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request, held until cpu_gnt
- cpu_we  input  1  1 = store, 0 = load
- cpu_addr  input  ADDR_W  CPU byte address
- cpu_wdata  input  DATA_W  CPU store data
- cpu_gnt  output  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  output  1  CPU load data valid
- cpu_rdata  output  DATA_W  CPU load data
- stall  output  1  cpu_req & ~cpu_gnt
- dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  DMA request, same rules as CPU
- dma_gnt  output  1  DMA request accepted this cycle
- dma_rvalid  output  1  DMA read data valid
- dma_rdata  output  DATA_W  DMA read data
- mem_read  output  1  registered read strobe to Data_Memory
- mem_write  output  1  registered write strobe to Data_Memory
- mem_addr  output  ADDR_W  registered address
- mem_wdata  output  DATA_W  registered write data
- mem_rdata  input  DATA_W  Data_Memory read data, valid one cycle after mem_read

## Operation

- Arbitration is combinational on the current requests and wait_cnt:
  - dma_gnt = dma_req & (~cpu_req | wait_cnt == MAX_WAIT).
  - cpu_gnt = cpu_req & ~dma_gnt.
  - At most one grant per cycle.
- Issue register: on a grant, it loads {read = ~we, write = we, addr, wdata, owner}. With no grant, mem_read and mem_write are 0, and mem_addr and mem_wdata hold their last values.
- Return register: captures {valid = mem_read, owner} each cycle. rvalid is asserted for the owner only. Both rdata outputs pass mem_rdata through.
- Writes produce no response; the grant is the completion.
- wait_cnt, 4-bit:
  - Increments when dma_req & ~dma_gnt, saturating at MAX_WAIT.
  - Clears on dma_gnt or when dma_req is low.
- A new grant is allowed every cycle. Back-to-back reads from either port are fully pipelined.
- A requester may change we, addr or wdata only after gnt. Changing them earlier is undefined.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert): the following are all 0 / zero:
  - mem_read, mem_write, mem_addr, mem_wdata
  - cpu_rvalid, dma_rvalid
  - wait_cnt
  - issue and return valid bits
- Grants and stall are combinational. During reset they still follow the request inputs, but the issue register does not load.
- Cycle N: gnt. Cycle N+1: mem_* driven. Cycle N+2: rvalid with rdata. Read latency is 2 cycles from grant.
- Write reaches memory at the rising edge ending cycle N+1.
- Reset mid-operation: all in-flight reads are dropped, and no rvalid is asserted after rst_n rises for accesses granted before reset.
- Simultaneous requests:
  - The CPU wins while wait_cnt < MAX_WAIT.
  - The DMA wins in the cycle wait_cnt == MAX_WAIT. The CPU stalls that cycle.
- A continuously requesting DMA under continuous CPU load is granted once every MAX_WAIT+1 cycles.

## Test plan

- Reset: hold rst_n=0 with both requests high, then release. Required: all mem_* and rvalid outputs are 0 during reset, and the first grant goes to the CPU.
- CPU only: load from addr 0x40 with mem_rdata=0xDEAD_BEEF at N+2. Required: cpu_gnt at N, mem_read=1 and mem_addr=0x40 at N+1, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF at N+2, dma_rvalid=0.
- DMA only: store 0x1234 to addr 0x80. Required: dma_gnt at N, mem_write=1 and mem_wdata=0x1234 at N+1, no rvalid.
- Contention with MAX_WAIT=4: both requesting continuously. Required grant sequence CPU,CPU,CPU,CPU,DMA repeating; stall=1 only in the DMA cycles; wait_cnt returns to 0 after each DMA grant.
- Pipelined mixed reads: CPU read at N, DMA read at N+1. Required: cpu_rvalid at N+2 only, dma_rvalid at N+3 only, each with the matching mem_rdata.
- Reset during an outstanding read: grant a CPU read at N and assert rst_n=0 at N+1. Required: cpu_rvalid stays 0 through and after reset.
